// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP MAC sequencer and its OPMODE delay line.
package dsp_pkg;

   // Sequencer states: collecting elements, waiting out the slice pipeline,
   // presenting the result.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // OPMODE encodings used by this block: bit 0 selects X=M, bit 3 selects Z=P.
   localparam logic [7:0] OPM_FIRST = 8'h01;
   localparam logic [7:0] OPM_ACC   = 8'h09;
   localparam logic [7:0] OPM_HOLD  = 8'h08;

   // Default slice pipeline depths and counter width.
   localparam int LAT_DEF    = 3;
   localparam int OP_DLY_DEF = 1;
   localparam int CNT_W_DEF  = 16;

   // Datapath widths of the slice ports.
   localparam int OPND_W = 18;
   localparam int P_W    = 48;

   // OPMODE for an accepted element: the first element of a vector restarts
   // the accumulator, later ones add onto P.
   function automatic logic [7:0] elem_opmode(input logic first);
      return first ? OPM_FIRST : OPM_ACC;
   endfunction

endpackage

// File: rtl/opmode_delay.sv
// OPMODE shift pipeline that delays the per-element OPMODE so it meets its
// operands inside the slice. Every stage resets to the hold encoding so the
// slice keeps P unchanged while the pipeline refills.
module opmode_delay
   import dsp_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic [7:0] opm_i,
   output logic [7:0] opm_o
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign opm_o = opm_i;
      end else begin : g_pipe
         logic [7:0] pipe_q [DEPTH];

         // Shift the OPMODE one stage per clock; reset fills every stage with hold.
         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               for (int i = 0; i < DEPTH; i++) begin
                  pipe_q[i] <= OPM_HOLD;
               end
            end else begin
               pipe_q[0] <= opm_i;
               for (int i = 1; i < DEPTH; i++) begin
                  pipe_q[i] <= pipe_q[i-1];
               end
            end
         end

         assign opm_o = pipe_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives an external DSP slice as a multiply-accumulate engine: streams
// operand pairs into A/B, sequences OPMODE so the first element restarts the
// accumulator, waits out the slice latency and presents the dot product.
module dsp_mac_sequencer
   import dsp_pkg::*;
#(
   parameter int LAT    = LAT_DEF,
   parameter int OP_DLY = OP_DLY_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                 CLK,
   input  logic                 RSTN,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OPND_W-1:0]    in_a,
   input  logic [OPND_W-1:0]    in_b,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [P_W-1:0]       out_data,
   output logic [CNT_W-1:0]     out_count,
   output logic [OPND_W-1:0]    dsp_a,
   output logic [OPND_W-1:0]    dsp_b,
   output logic [7:0]           dsp_opmode,
   input  logic [P_W-1:0]       dsp_p
);

   // Cycles spent draining after the last operand has been presented.
   localparam int DRAIN_CYC = LAT + OP_DLY;
   localparam int DRN_W     = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

   state_t              state_q, state_d;
   logic                alive_q;
   logic [OPND_W-1:0]   a_q, a_d;
   logic [OPND_W-1:0]   b_q, b_d;
   logic [7:0]          opm_q, opm_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DRN_W-1:0]    drain_q, drain_d;
   logic [P_W-1:0]      data_q, data_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                accept;

   // alive_q keeps in_ready low until the first edge after reset release.
   assign in_ready  = alive_q && ((state_q == IDLE) || (state_q == ACCUM));
   assign out_valid = (state_q == HOLD);
   assign accept    = in_valid && in_ready;

   assign out_data  = data_q;
   assign out_count = count_q;
   assign dsp_a     = a_q;
   assign dsp_b     = b_q;

   // Next-state, operand/OPMODE selection, element counting and result capture.
   always_comb begin
      state_d = state_q;
      a_d     = '0;
      b_d     = '0;
      opm_d   = OPM_HOLD;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      data_d  = data_q;
      count_d = count_q;

      case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               a_d   = in_a;
               b_d   = in_b;
               opm_d = elem_opmode(state_q == IDLE);
               if (state_q == IDLE) begin
                  cnt_d = CNT_W'(1);
               end else if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (in_last) begin
                  state_d = DRAIN;
                  drain_d = DRN_W'(DRAIN_CYC);
               end else begin
                  state_d = ACCUM;
               end
            end
         end

         DRAIN: begin
            if (drain_q == '0) begin
               data_d  = dsp_p;
               count_d = cnt_q;
               state_d = HOLD;
            end else begin
               drain_d = drain_q - DRN_W'(1);
            end
         end

         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, operand and result registers; reset discards any partial vector.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= IDLE;
         alive_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         opm_q   <= OPM_HOLD;
         cnt_q   <= '0;
         drain_q <= '0;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
         a_q     <= a_d;
         b_q     <= b_d;
         opm_q   <= opm_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   // opm_q lines up with dsp_a/dsp_b; the delay line shifts it OP_DLY cycles later.
   opmode_delay #(
      .DEPTH (OP_DLY)
   ) u_opmode_delay (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .opm_i (opm_q),
      .opm_o (dsp_opmode)
   );

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer driving a behavioural DSP slice model.
module tb_dsp_mac_sequencer;

   logic          CLK = 1'b0;
   logic          RSTN = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [17:0]   in_a = '0;
   logic [17:0]   in_b = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [47:0]   out_data;
   logic [15:0]   out_count;
   logic [17:0]   dsp_a;
   logic [17:0]   dsp_b;
   logic [7:0]    dsp_opmode;
   logic [47:0]   dsp_p;

   int passCount  = 0;
   int failCount  = 0;
   int checkCount = 0;
   int cyc;

   // Free-running 10 ns clock.
   always #5 CLK = ~CLK;

   dsp_mac_sequencer #(
      .LAT    (3),
      .OP_DLY (1),
      .CNT_W  (16)
   ) dut (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_count  (out_count),
      .dsp_a      (dsp_a),
      .dsp_b      (dsp_b),
      .dsp_opmode (dsp_opmode),
      .dsp_p      (dsp_p)
   );

   // Slice model configured as A0REG=0, A1REG=1, B1REG=1, MREG=1, PREG=1,
   // OPMODEREG=1 with all clock enables high; OPMODE bit 0 gives X=M, bit 3 gives Z=P.
   logic signed [17:0] slA1  = '0;
   logic signed [17:0] slB1  = '0;
   logic signed [47:0] slM   = '0;
   logic signed [47:0] slP   = '0;
   logic        [7:0]  slOpm = 8'h08;

   // Slice pipeline: input registers, multiplier register, OPMODE register, P register.
   always @(posedge CLK) begin
      slA1  <= dsp_a;
      slB1  <= dsp_b;
      slM   <= slA1 * slB1;
      slOpm <= dsp_opmode;
      slP   <= (slOpm[0] ? slM : 48'sd0) + (slOpm[3] ? slP : 48'sd0);
   end

   assign dsp_p = slP;

   // Move to 1 ns after the next rising edge, where outputs are sampled.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One comparison: counts it and reports tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Offer one element for a single cycle; in_ready must already be high.
   task automatic applyStimulus(input logic [17:0] a, input logic [17:0] b, input logic last);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      checkOutput("in_ready_at_offer", {47'd0, in_ready}, 48'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_a     = '0;
      in_b     = '0;
   endtask

   // Wait (bounded) for out_valid and report how many cycles it took.
   task automatic waitResult(output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 40) begin
         tick();
         cycles++;
      end
      checkOutput("out_valid_arrives", {47'd0, out_valid}, 48'd1);
   endtask

   // Abort guard in case the flow wedges somewhere outside a bounded wait.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence of scenarios.
   initial begin
      repeat (2) tick();

      // Reset values while RSTN is held low.
      checkOutput("rst_in_ready",   {47'd0, in_ready},  48'd0);
      checkOutput("rst_out_valid",  {47'd0, out_valid}, 48'd0);
      checkOutput("rst_out_data",   out_data,           48'd0);
      checkOutput("rst_out_count",  {32'd0, out_count}, 48'd0);
      checkOutput("rst_dsp_a",      {30'd0, dsp_a},     48'd0);
      checkOutput("rst_dsp_b",      {30'd0, dsp_b},     48'd0);
      checkOutput("rst_dsp_opmode", {40'd0, dsp_opmode}, 48'h08);

      // Release mid-cycle: in_ready only rises at the following edge.
      RSTN = 1'b1;
      #1;
      checkOutput("rel_in_ready_low", {47'd0, in_ready}, 48'd0);
      tick();
      checkOutput("rel_in_ready_high", {47'd0, in_ready}, 48'd1);

      // Three-element vector: 1*2 + 3*4 + 5*6 = 44.
      applyStimulus(18'd1, 18'd2, 1'b0);
      checkOutput("s1_dsp_a", {30'd0, dsp_a}, 48'd1);
      checkOutput("s1_dsp_b", {30'd0, dsp_b}, 48'd2);
      applyStimulus(18'd3, 18'd4, 1'b0);
      applyStimulus(18'd5, 18'd6, 1'b1);
      checkOutput("s1_drain_in_ready", {47'd0, in_ready}, 48'd0);
      waitResult(cyc);
      checkOutput("s1_latency",   48'(cyc), 48'd5);
      checkOutput("s1_out_data",  out_data, 48'd44);
      checkOutput("s1_out_count", {32'd0, out_count}, 48'd3);
      tick();
      checkOutput("s1_valid_one_cycle", {47'd0, out_valid}, 48'd0);
      checkOutput("s1_idle_in_ready",   {47'd0, in_ready},  48'd1);

      // Single signed element: -3 * 7 = -21.
      applyStimulus(18'h3FFFD, 18'd7, 1'b1);
      waitResult(cyc);
      checkOutput("s2_out_data",  out_data, 48'hFFFF_FFFF_FFEB);
      checkOutput("s2_out_count", {32'd0, out_count}, 48'd1);
      tick();

      // Bubbles between elements contribute nothing: 2*2 + 2*2 = 8.
      applyStimulus(18'd2, 18'd2, 1'b0);
      checkOutput("s3_dsp_a_elem", {30'd0, dsp_a}, 48'd2);
      tick();
      checkOutput("s3_dsp_a_bubble",   {30'd0, dsp_a}, 48'd0);
      checkOutput("s3_opmode_first",   {40'd0, dsp_opmode}, 48'h01);
      tick();
      checkOutput("s3_opmode_bubble",  {40'd0, dsp_opmode}, 48'h08);
      tick();
      applyStimulus(18'd2, 18'd2, 1'b1);
      tick();
      checkOutput("s3_opmode_acc", {40'd0, dsp_opmode}, 48'h09);
      waitResult(cyc);
      checkOutput("s3_out_data",  out_data, 48'd8);
      checkOutput("s3_out_count", {32'd0, out_count}, 48'd2);
      tick();

      // Back-pressure: result held while downstream stalls and input keeps offering.
      out_ready = 1'b0;
      applyStimulus(18'd3, 18'd5, 1'b1);
      waitResult(cyc);
      in_valid = 1'b1;
      in_a     = 18'd4;
      in_b     = 18'd4;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("s4_hold_in_ready",  {47'd0, in_ready},  48'd0);
         checkOutput("s4_hold_out_valid", {47'd0, out_valid}, 48'd1);
         checkOutput("s4_hold_out_data",  out_data, 48'd15);
         tick();
      end
      out_ready = 1'b1;
      tick();
      checkOutput("s4_release_in_ready",  {47'd0, in_ready},  48'd1);
      checkOutput("s4_release_out_valid", {47'd0, out_valid}, 48'd0);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_a     = '0;
      in_b     = '0;
      waitResult(cyc);
      checkOutput("s4_next_out_data",  out_data, 48'd16);
      checkOutput("s4_next_out_count", {32'd0, out_count}, 48'd1);
      tick();

      // Reset in the middle of a vector discards the partial 9*9.
      applyStimulus(18'd9, 18'd9, 1'b0);
      tick();
      tick();
      RSTN = 1'b0;
      #1;
      checkOutput("s5_rst_in_ready",  {47'd0, in_ready},   48'd0);
      checkOutput("s5_rst_opmode",    {40'd0, dsp_opmode}, 48'h08);
      checkOutput("s5_rst_out_count", {32'd0, out_count},  48'd0);
      tick();
      tick();
      RSTN = 1'b1;
      tick();
      applyStimulus(18'd1, 18'd1, 1'b1);
      waitResult(cyc);
      checkOutput("s5_out_data",  out_data, 48'd1);
      checkOutput("s5_out_count", {32'd0, out_count}, 48'd1);
      tick();

      // Back-to-back single-element vectors; the second restarts with OPMODE 01.
      applyStimulus(18'd1, 18'd1, 1'b1);
      waitResult(cyc);
      checkOutput("s6_first_out_data", out_data, 48'd1);
      tick();
      applyStimulus(18'd2, 18'd3, 1'b1);
      checkOutput("s6_dsp_a", {30'd0, dsp_a}, 48'd2);
      checkOutput("s6_dsp_b", {30'd0, dsp_b}, 48'd3);
      tick();
      checkOutput("s6_opmode_first", {40'd0, dsp_opmode}, 48'h01);
      waitResult(cyc);
      checkOutput("s6_second_out_data",  out_data, 48'd6);
      checkOutput("s6_second_out_count", {32'd0, out_count}, 48'd1);
      tick();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
